ntt_seq_ctrl: RTL and testbench
===============================

Name: ntt_seq_ctrl

Overview:
- Sequencer for the 64-lane matrix-vector NTT datapath (one rowcalc multiply-accumulate lane per output row).
- Accepts a start request and walks the column index 0..N-1 for the operand memories. Each column issues one x element plus one twiddle column to all lanes.
- Stalls while operands are not ready, then waits out the lane pipeline latency, strobes capture of the y bank and reports done.
- Replaces ad-hoc counting inside the transform top; sits between the host/command logic and the lane array.

Parameters:
- N, 64, number of columns issued per transform (equals lane count); N >= 2.
- LAT, 8, lane pipeline depth in cycles from an issued column to its result being visible at the lane output; LAT >= 1.
- IDXW, $clog2(N), width of the column index.
- SCW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a transform; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current transform.
- operand_ready  in  1  operand memories hold valid data for col_idx this cycle.
- busy  out  1  high in every state except IDLE.
- col_idx  out  IDXW  column currently presented to the operand memories.
- issue_valid  out  1  lanes consume x[col_idx] and w[*][col_idx] this cycle.
- lane_clr  out  1  first column; lanes load the product instead of accumulating it.
- capture  out  1  one-cycle strobe; the y bank loads the lane outputs.
- done  out  1  one-cycle completion pulse.
- stall_cycles  out  SCW  count of ISSUE cycles with operand_ready low; saturating.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, col_idx 0, drain_cnt 0, stall_cycles 0. busy, issue_valid, lane_clr, capture and done are all 0.
- States: IDLE, ISSUE, DRAIN, DONE. State is held in registers. issue_valid, lane_clr, capture, busy and done are decoded combinationally from the registers and operand_ready.
- IDLE:
  - If start is 1: go to ISSUE, col_idx <= 0, stall_cycles <= 0.
  - Otherwise hold.
- ISSUE:
  - issue_valid = operand_ready. lane_clr = issue_valid && col_idx == 0.
  - If operand_ready is 1 and col_idx == N-1: go to DRAIN, drain_cnt <= LAT-1.
  - If operand_ready is 1 otherwise: col_idx <= col_idx + 1.
  - If operand_ready is 0: hold col_idx and increment stall_cycles, saturating at 2^SCW-1.
- DRAIN:
  - issue_valid = 0; col_idx holds N-1.
  - capture = (drain_cnt == 0).
  - If drain_cnt == 0: go to DONE. Otherwise drain_cnt decrements.
- DONE: done = 1 for exactly one cycle, then go to IDLE. A start asserted during DONE is ignored.
- start is ignored in every state except IDLE; it is never queued.
- abort = 1 in ISSUE, DRAIN or DONE:
  - Next state is IDLE and col_idx <= 0.
  - In that same cycle issue_valid, capture and done are forced to 0.
  - stall_cycles keeps its value.
  - abort takes priority over every other transition. abort in IDLE has no effect, and a simultaneous start in IDLE is suppressed.
- Latency with operand_ready held at 1, start sampled at edge 0:
  - issue_valid in cycles 1..N.
  - capture in cycle N+LAT.
  - done in cycle N+LAT+1.
  - busy in cycles 1..N+LAT+1.
  - For N=64, LAT=8: capture in cycle 72, done in cycle 73.
- Each stall cycle delays capture and done by exactly one cycle.
- Arithmetic: col_idx never wraps (the exit happens at N-1). drain_cnt is $clog2(LAT+1) bits wide. When LAT == 1, capture occurs in the first DRAIN cycle.
- If rst is asserted mid-transform, all outputs drop asynchronously to their reset values. No capture and no done are produced.

Decomposition:
- ntt_pkg holds:
  - the state enum ntt_seq_state_t (IDLE, ISSUE, DRAIN, DONE);
  - constants NTT_N = 64 and NTT_LAT = 8;
  - NTT_IDXW.
- Single module; no sub-module is warranted. The drain down-counter and the saturating stall counter are small enough to stay inline.

Test Plan:
- Nominal: pulse start, operand_ready = 1 throughout, N=64, LAT=8 -> issue_valid in cycles 1..64, col_idx 0..63, lane_clr only in cycle 1, capture only in cycle 72, done only in cycle 73, stall_cycles = 0.
- Stalls: drop operand_ready for 3 cycles at col_idx 10 and for 2 cycles at col_idx 63 -> col_idx holds during each gap, no issue_valid while stalled, capture in cycle 77, done in cycle 78, stall_cycles = 5.
- Start handling: hold start high continuously -> back-to-back transforms with done at cycle 73, next issue starting at cycle 75, start ignored in DONE. Also pulse start at cycle 30 of a transform -> ignored, exactly one done.
- Abort: assert abort in cycle 40 (ISSUE), and separately in cycle 70 (DRAIN) -> IDLE the next cycle, busy 0, no capture or done ever. A following start runs a full nominal transform.
- Reset mid-operation: drive rst low asynchronously between edges at cycle 20 -> busy and issue_valid drop immediately, col_idx = 0, stall_cycles = 0. After release, start produces nominal timing.
- Saturation and edge parameters: with SCW=4, stall 20 cycles -> stall_cycles = 15. With LAT=1, N=2 -> issue in cycles 1..2, capture in cycle 3, done in cycle 4.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and default sizing for the NTT column sequencer.
// The lane array and command logic use the same defaults.
package ntt_pkg;

  localparam int NTT_N    = 64;
  localparam int NTT_LAT  = 8;
  localparam int NTT_IDXW = $clog2(NTT_N);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } ntt_seq_state_t;

endpackage

// File: rtl/ntt_seq_ctrl.sv
// Column sequencer for the matrix-vector NTT lanes.
// It issues N columns while stalling on operand_ready, then waits out the
// lane pipeline, strobes capture, and pulses done.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int N    = NTT_N,
  parameter int LAT  = NTT_LAT,
  parameter int IDXW = $clog2(N),
  parameter int SCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            operand_ready,
  output logic            busy,
  output logic [IDXW-1:0] col_idx,
  output logic            issue_valid,
  output logic            lane_clr,
  output logic            capture,
  output logic            done,
  output logic [SCW-1:0]  stall_cycles
);

  localparam int DW = $clog2(LAT + 1);
  localparam logic [IDXW-1:0] LAST_COL   = IDXW'(N - 1);
  localparam logic [DW-1:0]   DRAIN_INIT = DW'(LAT - 1);
  localparam logic [SCW-1:0]  STALL_MAX  = '1;

  ntt_seq_state_t  state_q, state_d;
  logic [IDXW-1:0] col_q, col_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [SCW-1:0]  stall_q, stall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    drain_d     = drain_q;
    stall_d     = stall_q;
    busy        = (state_q != IDLE);
    issue_valid = 1'b0;
    lane_clr    = 1'b0;
    capture     = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          col_d   = '0;
          stall_d = '0;
        end
      end
      ISSUE: begin
        issue_valid = operand_ready;
        if (operand_ready) begin
          if (col_q == LAST_COL) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      DRAIN: begin
        capture = (drain_q == '0);
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Cancel wins over every transition and silences the strobes this cycle.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      col_d       = '0;
      drain_d     = drain_q;
      stall_d     = stall_q;
      issue_valid = 1'b0;
      capture     = 1'b0;
      done        = 1'b0;
    end

    lane_clr = issue_valid && (col_q == '0);
  end

  assign col_idx      = col_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Scoreboard bench: the driver pushes the expected per-cycle outputs while it
// drives inputs; a negedge monitor pops and compares them.
module tb_ntt_seq_ctrl;

  typedef struct {
    int busy;
    int iv;
    int clr;
    int cap;
    int done;
    int col;
    int stall;
  } exp_t;

  logic clk;
  logic rst;
  logic start_s [2];
  logic abort_s [2];
  logic ready_s [2];

  logic        busy_w [2];
  logic        iv_w   [2];
  logic        clr_w  [2];
  logic        cap_w  [2];
  logic        done_w [2];
  logic [15:0] col_w  [2];
  logic [15:0] st_w   [2];

  logic [5:0]  col_a;
  logic [0:0]  col_b;
  logic [15:0] st_a;
  logic [3:0]  st_b;

  int checks   = 0;
  int failures = 0;
  int tcyc     = 0;

  int n_of   [2] = '{64, 2};
  int lat_of [2] = '{8, 1};
  int smax   [2] = '{65535, 15};
  int m_col  [2] = '{0, 0};
  int m_stall[2] = '{0, 0};

  exp_t q0[$];
  exp_t q1[$];

  ntt_seq_ctrl #(.N(64), .LAT(8), .SCW(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
    .operand_ready(ready_s[0]), .busy(busy_w[0]), .col_idx(col_a),
    .issue_valid(iv_w[0]), .lane_clr(clr_w[0]), .capture(cap_w[0]),
    .done(done_w[0]), .stall_cycles(st_a)
  );

  ntt_seq_ctrl #(.N(2), .LAT(1), .SCW(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
    .operand_ready(ready_s[1]), .busy(busy_w[1]), .col_idx(col_b),
    .issue_valid(iv_w[1]), .lane_clr(clr_w[1]), .capture(cap_w[1]),
    .done(done_w[1]), .stall_cycles(st_b)
  );

  assign col_w[0] = {10'd0, col_a};
  assign col_w[1] = {15'd0, col_b};
  assign st_w[0]  = st_a;
  assign st_w[1]  = {12'd0, st_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string tag, input int u, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s unit=%0d t=%0d observed=%0d expected=%0d", tag, u, tcyc, obs, expv);
    end
  endtask

  task automatic cmp(input int u, input exp_t e);
    chk("busy",        u, {31'd0, busy_w[u]}, e.busy);
    chk("issue_valid", u, {31'd0, iv_w[u]},   e.iv);
    chk("lane_clr",    u, {31'd0, clr_w[u]},  e.clr);
    chk("capture",     u, {31'd0, cap_w[u]},  e.cap);
    chk("done",        u, {31'd0, done_w[u]}, e.done);
    chk("col_idx",     u, {16'd0, col_w[u]},  e.col);
    chk("stall_cycles",u, {16'd0, st_w[u]},   e.stall);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp(0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp(1, e);
    end
  end

  task automatic push(input int u, input exp_t e);
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step(input int u, input logic st, input logic ab, input logic rd, input exp_t e);
    start_s[u] = st;
    abort_s[u] = ab;
    ready_s[u] = rd;
    push(u, e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u, input int k, input logic st, input logic ab);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      e = '{0, 0, 0, 0, 0, m_col[u], m_stall[u]};
      step(u, st, ab, 1'($urandom_range(0, 1)), e);
    end
  endtask

  // One cycle of a transform, with an optional abort or mid-cycle reset.
  task automatic emit(input int u, input exp_t e, input logic rd, input logic st,
                      input int c, input int abort_c, input int rst_c, output bit stop);
    exp_t ea;
    stop = 1'b0;
    if (c == abort_c) begin
      ea = e;
      ea.iv = 0; ea.clr = 0; ea.cap = 0; ea.done = 0;
      step(u, st, 1'b1, rd, ea);
      m_col[u] = 0;
      stop = 1'b1;
    end else if (c == rst_c) begin
      start_s[u] = st;
      abort_s[u] = 1'b0;
      ready_s[u] = rd;
      push(u, e);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_busy",  u, {31'd0, busy_w[u]}, 0);
      chk("rst_iv",    u, {31'd0, iv_w[u]},   0);
      chk("rst_col",   u, {16'd0, col_w[u]},  0);
      chk("rst_stall", u, {16'd0, st_w[u]},   0);
      start_s[u] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      m_col   = '{0, 0};
      m_stall = '{0, 0};
      stop = 1'b1;
    end else begin
      step(u, st, 1'b0, rd, e);
    end
  endtask

  // Full transform starting from IDLE; cycle 0 is the cycle start is sampled.
  task automatic run(input int u, input int sc1, input int sn1, input int sc2, input int sn2,
                     input bit hold, input int pulse_c, input int abort_c, input int rst_c);
    int n, lat, c, nst;
    logic rd;
    exp_t e;
    bit stop;
    n   = n_of[u];
    lat = lat_of[u];
    e = '{0, 0, 0, 0, 0, m_col[u], m_stall[u]};
    step(u, 1'b1, 1'b0, 1'($urandom_range(0, 1)), e);
    m_col[u]   = 0;
    m_stall[u] = 0;
    c = 1;
    for (int k = 0; k < n; k++) begin
      nst = ((k == sc1) ? sn1 : 0) + ((k == sc2) ? sn2 : 0);
      for (int s = 0; s <= nst; s++) begin
        rd = (s < nst) ? 1'b0 : 1'b1;
        e = '{1, int'(rd), int'(rd && k == 0), 0, 0, k, m_stall[u]};
        emit(u, e, rd, hold || c == pulse_c, c, abort_c, rst_c, stop);
        if (stop) return;
        if (!rd) m_stall[u] = (m_stall[u] < smax[u]) ? m_stall[u] + 1 : smax[u];
        c++;
      end
    end
    for (int d = lat - 1; d >= 0; d--) begin
      e = '{1, 0, 0, int'(d == 0), 0, n - 1, m_stall[u]};
      emit(u, e, 1'($urandom_range(0, 1)), hold || c == pulse_c, c, abort_c, rst_c, stop);
      if (stop) return;
      c++;
    end
    e = '{1, 0, 0, 0, 1, n - 1, m_stall[u]};
    emit(u, e, 1'($urandom_range(0, 1)), hold || c == pulse_c, c, abort_c, rst_c, stop);
    if (stop) return;
    m_col[u] = n - 1;
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      abort_s[u] = 1'b0;
      ready_s[u] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_busy",  u, {31'd0, busy_w[u]}, 0);
      chk("reset_iv",    u, {31'd0, iv_w[u]},   0);
      chk("reset_clr",   u, {31'd0, clr_w[u]},  0);
      chk("reset_cap",   u, {31'd0, cap_w[u]},  0);
      chk("reset_done",  u, {31'd0, done_w[u]}, 0);
      chk("reset_col",   u, {16'd0, col_w[u]},  0);
      chk("reset_stall", u, {16'd0, st_w[u]},   0);
    end
    rst = 1'b1;
    idle(0, 2, 1'b0, 1'b0);

    // Nominal: capture in cycle 72, done in 73.
    run(0, -1, 0, -1, 0, 1'b0, -1, -1, -1);
    idle(0, 2, 1'b0, 1'b0);

    // Stalls at col 10 (3) and col 63 (2): capture 77, done 78, count 5.
    run(0, 10, 3, 63, 2, 1'b0, -1, -1, -1);
    idle(0, 2, 1'b0, 1'b0);

    // start held: back-to-back, start ignored during DONE.
    run(0, -1, 0, -1, 0, 1'b1, -1, -1, -1);
    run(0, -1, 0, -1, 0, 1'b0, -1, -1, -1);
    idle(0, 1, 1'b0, 1'b0);

    // Stray start pulse mid-transform is ignored.
    run(0, -1, 0, -1, 0, 1'b0, 30, -1, -1);
    idle(0, 2, 1'b0, 1'b0);

    // Abort in ISSUE, start suppressed by abort in IDLE, abort in DRAIN.
    run(0, -1, 0, -1, 0, 1'b0, -1, 40, -1);
    idle(0, 1, 1'b0, 1'b0);
    idle(0, 1, 1'b1, 1'b1);
    idle(0, 2, 1'b0, 1'b0);
    run(0, -1, 0, -1, 0, 1'b0, -1, 70, -1);
    idle(0, 2, 1'b0, 1'b0);
    run(0, -1, 0, -1, 0, 1'b0, -1, -1, -1);
    idle(0, 1, 1'b0, 1'b0);

    // Asynchronous reset at cycle 20 after two stall cycles.
    run(0, 5, 2, -1, 0, 1'b0, -1, -1, 20);
    idle(0, 1, 1'b0, 1'b0);
    run(0, -1, 0, -1, 0, 1'b0, -1, -1, -1);
    idle(0, 1, 1'b0, 1'b0);

    // N=2, LAT=1: issue 1..2, capture 3, done 4; then saturation at 15.
    idle(1, 1, 1'b0, 1'b0);
    run(1, -1, 0, -1, 0, 1'b0, -1, -1, -1);
    idle(1, 1, 1'b0, 1'b0);
    run(1, 0, 20, -1, 0, 1'b0, -1, -1, -1);
    idle(1, 2, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(q0.size() + q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
